// File: rtl/avaliador_polinomio_pkg.sv
// rtl/avaliador_polinomio_pkg.sv - shared types for the Horner polynomial evaluator
package avaliador_polinomio_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // ULA operation select
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } ula_op_t;

  // Coefficient index width: enough to hold DEGREE-1, never narrower than one bit
  function automatic int idx_width(input int degree);
    return (degree > 1) ? $clog2(degree) : 1;
  endfunction

endpackage

// File: rtl/avaliador_polinomio_ula_n.sv
// rtl/avaliador_polinomio_ula_n.sv - combinational unsigned add/multiply unit with overflow
module ula_n
  import avaliador_polinomio_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  ula_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_sum;

  assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign w_sum  = {1'b0, a} + {1'b0, b};

  // Select the operation; overflow is a nonzero upper product half or the adder carry
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    if (op == OP_MUL) begin
      result   = w_prod[WIDTH-1:0];
      overflow = |w_prod[2*WIDTH-1:WIDTH];
    end else begin
      result   = w_sum[WIDTH-1:0];
      overflow = w_sum[WIDTH];
    end
  end

endmodule

// File: rtl/avaliador_polinomio.sv
// rtl/avaliador_polinomio.sv - polynomial evaluator by Horner's rule with start/busy/done handshake
module avaliador_polinomio
  import avaliador_polinomio_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEGREE = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          x,
  input  logic [(DEGREE+1)*WIDTH-1:0] coefs,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          resultado,
  output logic                      ovf
);

  localparam int IDX_W = idx_width(DEGREE);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(DEGREE - 1);

  state_t r_state;
  state_t w_next;

  // c_D goes straight into the accumulator, so only c_0..c_{D-1} are kept
  logic [DEGREE*WIDTH-1:0] r_coefs;
  logic [WIDTH-1:0]        r_x;
  logic [WIDTH-1:0]        r_acc;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_ovf_int;
  logic [WIDTH-1:0]        r_resultado;
  logic                    r_ovf;

  logic [WIDTH-1:0]        w_coef;
  ula_op_t                 w_op;
  logic [WIDTH-1:0]        w_ula_b;
  logic [WIDTH-1:0]        w_ula_y;
  logic                    w_ula_ovf;

  // Coefficient mux: pick c_idx from the captured coefficient set
  always_comb begin
    w_coef = '0;
    for (int i = 0; i < DEGREE; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_coef = r_coefs[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_op    = (r_state == MUL) ? OP_MUL : OP_ADD;
  assign w_ula_b = (r_state == MUL) ? r_x : w_coef;

  ula_n #(
    .WIDTH (WIDTH)
  ) u_ula (
    .a        (r_acc),
    .b        (w_ula_b),
    .op       (w_op),
    .result   (w_ula_y),
    .overflow (w_ula_ovf)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = MUL;
        end
      end
      MUL: begin
        busy   = 1'b1;
        w_next = ADD;
      end
      ADD: begin
        busy   = 1'b1;
        w_next = (r_idx == '0) ? DONE : MUL;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, Horner accumulation, index countdown and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_coefs     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_ovf_int   <= 1'b0;
      r_resultado <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x       <= x;
            r_coefs   <= coefs[DEGREE*WIDTH-1:0];
            r_acc     <= coefs[DEGREE*WIDTH +: WIDTH];
            r_idx     <= IDX_FIRST;
            r_ovf_int <= 1'b0;
          end
        end
        MUL: begin
          r_acc     <= w_ula_y;
          r_ovf_int <= r_ovf_int | w_ula_ovf;
        end
        ADD: begin
          r_acc     <= w_ula_y;
          r_ovf_int <= r_ovf_int | w_ula_ovf;
          if (r_idx == '0) begin
            r_resultado <= w_ula_y;
            r_ovf       <= r_ovf_int | w_ula_ovf;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resultado = r_resultado;
  assign ovf       = r_ovf;

endmodule
